rv_multicycle_core: RTL
=======================

// Module: rv_multicycle_core
// PURPOSE
//   Parametrised multi-cycle RV32I-subset integer core: fetch/decode/execute/writeback FSM.
//   Supports R-type ALU (opcode 0110011) and I-type ALU (0010011), with a req/ack instruction-memory port.
//   Fetch can stall for any number of cycles. Unsupported encodings raise a sticky illegal flag and halt.
//   Top-level compute core of the SoC, driven by the imem/bus fabric.
// PARAMETERS
//   XLEN      32  datapath/register/PC width (>=32; instruction word is always 32 bit)
//   NREGS     32  architectural registers (16 or 32); register index = instr[RW-1:..], RW=$clog2(NREGS)
//   RESET_PC  0   PC value loaded on reset
// PORTS
//   clk         in   1     core clock, rising edge
//   rst         in   1     synchronous, active-high reset
//   imem_req    out  1     fetch request; high only in S_FETCH
//   imem_addr   out  XLEN  fetch address (= pc), stable while imem_req high
//   imem_ack    in   1     fetch data valid this cycle; ignored unless imem_req high
//   imem_rdata  in   32    instruction word, sampled when imem_req && imem_ack
//   retire      out  1     one-cycle pulse per committed instruction
//   zero_flag   out  1     1 when last retired ALU result == 0
//   illegal     out  1     sticky; set on unsupported encoding, cleared only by rst
//   dbg_pc      out  XLEN  current pc
// BEHAVIOUR
//   Reset: state=S_IDLE, pc=RESET_PC, IR=0, all regs=0, retire=0, zero_flag=0, illegal=0, imem_req=0.
//   rst dominates every cycle: an in-flight fetch is abandoned; a late imem_ack outside S_FETCH is ignored.
//   FSM: S_IDLE->S_FETCH (always, next cycle).
//     S_FETCH: imem_req=1. Stay until imem_ack. On ack, IR<=imem_rdata, go to S_DECODE.
//     S_DECODE: read rs1/rs2 into A/B, build sign-extended imm, check legality.
//       Legal -> S_EXEC. Illegal -> illegal<=1, go to S_HALT.
//     S_EXEC: ALUOUT<=ALU(A, B or imm). Go to S_WB.
//     S_WB: write ALUOUT to rd if rd!=0; pc<=pc+4 (mod 2^XLEN, wraps); retire=1; zero_flag<=(ALUOUT==0).
//       Then go to S_FETCH.
//     S_HALT: terminal; no req, no writes; exits only via rst.
//   Latency: 4 cycles per instruction with zero-wait ack; each ack wait cycle adds 1.
//   ALU ops: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
//     I-forms: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI.
//     Shift amount = low $clog2(XLEN) bits of B/imm; SLT/SLTU yield 0 or 1 zero-extended.
//     Results are truncated to XLEN.
//   Illegal when any of:
//     opcode not in {0110011, 0010011};
//     R-type funct7 not 0000000, or 0100000 with funct3 other than 000/101;
//     SLLI/SRLI/SRAI with bad funct7 (imm[11:5]);
//     NREGS=16 and any of rs1/rs2/rd >= 16.
//   x0 reads 0; writes to x0 are discarded, but zero_flag still updates.
//   imem_addr is held constant for the whole S_FETCH stay; no new request until the next S_FETCH.
// STRUCTURE
//   core_pkg: opcode constants (OP_R, OP_I), funct3/funct7 codes, alu_op_e enum, state_e enum.
//   Sub-module rv_regfile #(XLEN,NREGS):
//     2 asynchronous read ports, 1 synchronous write port, x0 hardwired to 0,
//     write-enable gated on rd!=0, all entries cleared by rst.
//   ALU: combinational function or always block inside the core; no separate module.
// TESTING
//   1. Zero-wait ack, program ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2
//      -> x3=2, retire every 4th cycle, zero_flag=0.
//   2. SUB x4,x1,x1 -> x4=0, zero_flag=1 in the cycle after retire.
//      ADDI x0,x0,7 -> x0 reads 0, retire pulses, zero_flag=0.
//   3. Ack delayed 3 cycles -> imem_req and imem_addr held stable 4 cycles, IR captured once.
//      Instruction completes in 7 cycles.
//   4. Fetch 0xFFFFFFFF (illegal opcode) -> illegal=1 after decode, no retire, imem_req stays 0.
//      Assert rst -> illegal=0, pc=RESET_PC.
//   5. SRAI x5,x6,31 with x6=0x80000000 -> 0xFFFFFFFF.
//      SLTU x7,x0,x6 -> 1. SLT x8,x6,x0 -> 1.
//   6. rst asserted during S_FETCH with ack arriving the same cycle -> IR unchanged, no retire.
//      Core refetches from RESET_PC. pc=0xFFFFFFFC retire -> pc wraps to 0.

Source files
------------

// File: rtl/rv_multicycle_core_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: opcodes, funct codes, ALU ops, FSM states.
package rv_multicycle_core_pkg;

  localparam logic [6:0] OpR = 7'b0110011;
  localparam logic [6:0] OpI = 7'b0010011;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Sr     = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StWb, StHalt
  } state_e;

endpackage

// File: rtl/rv_multicycle_core_if.sv
// Instruction-memory req/ack port: the core is the master, the imem/bus fabric the slave.
interface rv_multicycle_core_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/rv_multicycle_core_regfile.sv
// Architectural register file: two async read ports, one sync write port, x0 hardwired to zero.
module rv_multicycle_core_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned RW   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [RW-1:0]   raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [RW-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o,
  input  logic            we_i,
  input  logic [RW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I ALU-subset core: fetch/decode/execute/writeback FSM with a req/ack imem port.
module rv_multicycle_core
  import rv_multicycle_core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rv_multicycle_core_if.master imem,
  output logic                 retire_o,
  output logic                 zero_flag_o,
  output logic                 illegal_o,
  output logic [XLEN-1:0]      dbg_pc_o
);

  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned SW = $clog2(XLEN);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] alu_q;
  alu_op_e         op_q;
  logic            zero_q;
  logic            illegal_q;

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd_f;
  logic [4:0]      rs1_f;
  logic [4:0]      rs2_f;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  alu_op_e         dec_op;
  logic            dec_illegal;

  assign opcode   = ir_q[6:0];
  assign rd_f     = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1_f    = ir_q[19:15];
  assign rs2_f    = ir_q[24:20];
  assign funct7   = ir_q[31:25];
  assign imm_sext = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};

  // For I-type shifts funct7 aliases imm[11:5], so one decode covers both forms.
  always_comb begin
    dec_op      = AluAdd;
    dec_illegal = 1'b0;
    unique case (funct3)
      F3AddSub: dec_op = (opcode == OpR && funct7 == F7Alt) ? AluSub : AluAdd;
      F3Sll:    dec_op = AluSll;
      F3Slt:    dec_op = AluSlt;
      F3Sltu:   dec_op = AluSltu;
      F3Xor:    dec_op = AluXor;
      F3Sr:     dec_op = (funct7 == F7Alt) ? AluSra : AluSrl;
      F3Or:     dec_op = AluOr;
      F3And:    dec_op = AluAnd;
    endcase
    if (opcode == OpR) begin
      if (!(funct7 == F7Base ||
            (funct7 == F7Alt && (funct3 == F3AddSub || funct3 == F3Sr)))) begin
        dec_illegal = 1'b1;
      end
    end else if (opcode == OpI) begin
      if (funct3 == F3Sll && funct7 != F7Base) dec_illegal = 1'b1;
      if (funct3 == F3Sr && funct7 != F7Base && funct7 != F7Alt) dec_illegal = 1'b1;
    end else begin
      dec_illegal = 1'b1;
    end
    if (NREGS < 32) begin
      if (32'(rd_f) >= NREGS || 32'(rs1_f) >= NREGS ||
          (opcode == OpR && 32'(rs2_f) >= NREGS)) begin
        dec_illegal = 1'b1;
      end
    end
  end

  function automatic logic [XLEN-1:0] alu(alu_op_e op, logic [XLEN-1:0] op_a,
                                          logic [XLEN-1:0] op_b);
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] res;
    shamt = op_b[SW-1:0];
    case (op)
      AluAdd:  res = op_a + op_b;
      AluSub:  res = op_a - op_b;
      AluSll:  res = op_a << shamt;
      AluSlt:  res = XLEN'($signed(op_a) < $signed(op_b));
      AluSltu: res = XLEN'(op_a < op_b);
      AluXor:  res = op_a ^ op_b;
      AluSrl:  res = op_a >> shamt;
      AluSra:  res = $signed(op_a) >>> shamt;
      AluOr:   res = op_a | op_b;
      AluAnd:  res = op_a & op_b;
      default: res = op_a + op_b;
    endcase
    return res;
  endfunction

  rv_multicycle_core_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .raddr_a_i (ir_q[15 +: RW]),
    .rdata_a_o (rs1_data),
    .raddr_b_i (ir_q[20 +: RW]),
    .rdata_b_o (rs2_data),
    .we_i      (state_q == StWb),
    .waddr_i   (ir_q[7 +: RW]),
    .wdata_i   (alu_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      op_q      <= AluAdd;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (imem.ack) begin
            ir_q    <= imem.rdata;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (dec_illegal) begin
            illegal_q <= 1'b1;
            state_q   <= StHalt;
          end else begin
            a_q     <= rs1_data;
            b_q     <= (opcode == OpR) ? rs2_data : imm_sext;
            op_q    <= dec_op;
            state_q <= StExec;
          end
        end
        StExec: begin
          alu_q   <= alu(op_q, a_q, b_q);
          state_q <= StWb;
        end
        StWb: begin
          pc_q    <= pc_q + XLEN'(4);
          zero_q  <= (alu_q == '0);
          state_q <= StFetch;
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  // pc only moves in StWb, so the address is stable for the whole fetch.
  assign imem.req    = (state_q == StFetch);
  assign imem.addr   = pc_q;
  assign retire_o    = (state_q == StWb);
  assign zero_flag_o = zero_q;
  assign illegal_o   = illegal_q;
  assign dbg_pc_o    = pc_q;

endmodule
